// File: rtl/return_pack_pkg.sv
// Shared types, default geometry and helper functions for the return packing FIFO.
package return_pack_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned DEF_IN_BYTES  = 16;
  localparam int unsigned DEF_OUT_BYTES = 8;
  localparam int unsigned DEF_DEPTH     = 64;
  localparam int unsigned DEF_MAX_AVAIL = 34;

  localparam int unsigned DEF_TAKE_W  = $clog2(DEF_IN_BYTES + 1);
  localparam int unsigned DEF_AVAIL_W = $clog2(DEF_MAX_AVAIL + 1);
  localparam int unsigned DEF_LVL_W   = $clog2(DEF_DEPTH) + 1;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Contiguous mask with the low n bits set.
  function automatic logic [31:0] keep_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/return_pack_fifo_if.sv
// Upstream shift-register port and AXI-Stream output port of the packing FIFO.
interface shift_src_if import return_pack_pkg::*; #(
  parameter int unsigned IN_BYTES  = DEF_IN_BYTES,
  parameter int unsigned MAX_AVAIL = DEF_MAX_AVAIL
);
  byte_t [IN_BYTES-1:0]            in_data;
  logic  [$clog2(MAX_AVAIL+1)-1:0] in_bytes;
  logic                            in_shift;
  logic  [$clog2(IN_BYTES+1)-1:0]  in_take;
  logic                            in_eos;
  logic                            in_eos_ack;

  modport master (output in_data, in_bytes, in_eos, input in_shift, in_take, in_eos_ack);
  modport slave  (input in_data, in_bytes, in_eos, output in_shift, in_take, in_eos_ack);
endinterface

// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
// once out_valid is high, out_data/out_keep/out_last hold until that transfer.
interface axis_if import return_pack_pkg::*; #(
  parameter int unsigned OUT_BYTES = DEF_OUT_BYTES
);
  byte_t [OUT_BYTES-1:0] out_data;
  logic  [OUT_BYTES-1:0] out_keep;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, out_keep, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_keep, out_last, out_valid, output out_ready);
endinterface

// File: rtl/return_pack_ring.sv
// Byte ring: multi-byte wrapping write and combinational wrapping read at arbitrary offsets.
module return_pack_ring import return_pack_pkg::*; #(
  parameter int unsigned IN_BYTES  = DEF_IN_BYTES,
  parameter int unsigned OUT_BYTES = DEF_OUT_BYTES,
  parameter int unsigned DEPTH     = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH)-1:0]       wr_ptr,
  input  logic [$clog2(IN_BYTES+1)-1:0]  wr_n,
  input  byte_t [IN_BYTES-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]       rd_ptr,
  output byte_t [OUT_BYTES-1:0]          rd_data
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  byte_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_addr [IN_BYTES];
  logic             wr_en   [IN_BYTES];
  logic [PTR_W-1:0] rd_addr [OUT_BYTES];

  // Addresses wrap naturally through the PTR_W-bit sum.
  always_comb begin
    for (int i = 0; i < int'(IN_BYTES); i++) begin
      wr_addr[i] = wr_ptr + PTR_W'(i);
      wr_en[i]   = i < int'(wr_n);
    end
    for (int j = 0; j < int'(OUT_BYTES); j++) begin
      rd_addr[j] = rd_ptr + PTR_W'(j);
      rd_data[j] = mem[rd_addr[j]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(IN_BYTES); i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
    end
  end

endmodule

// File: rtl/return_pack_fifo.sv
// Packs variable-size byte groups from a shift-register source into fixed-width
// AXI-Stream beats with backpressure, partial final beat and end-of-stream handshake.
module return_pack_fifo import return_pack_pkg::*; #(
  parameter int unsigned IN_BYTES  = DEF_IN_BYTES,
  parameter int unsigned OUT_BYTES = DEF_OUT_BYTES,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned MAX_AVAIL = DEF_MAX_AVAIL
) (
  input  logic                     clk,
  input  logic                     resetn,
  shift_src_if.slave               src,
  axis_if.master                   axis,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned TAKE_W = $clog2(IN_BYTES + 1);
  localparam int unsigned BEAT_W = $clog2(OUT_BYTES + 1);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  eos_pend;
  logic [TAKE_W-1:0]     take, take_eff;
  logic [LVL_W-1:0]      space;
  logic                  shift_ok, eos_hit, formable, load, beat_last;
  logic [BEAT_W-1:0]     beat_n;
  logic [OUT_BYTES-1:0]  beat_keep;
  byte_t [OUT_BYTES-1:0] rd_data, beat_data;

  return_pack_ring #(
    .IN_BYTES (IN_BYTES),
    .OUT_BYTES(OUT_BYTES),
    .DEPTH    (DEPTH)
  ) u_ring (
    .clk    (clk),
    .wr_ptr (wr_ptr),
    .wr_n   (take_eff),
    .wr_data(src.in_data),
    .rd_ptr (rd_ptr),
    .rd_data(rd_data)
  );

  // Intake is all-or-nothing and gets no credit for a pop in the same cycle.
  // An empty last beat is formed only when no last beat is already waiting.
  always_comb begin
    take      = TAKE_W'(min_u(32'(src.in_bytes), IN_BYTES));
    space     = LVL_W'(DEPTH) - level;
    shift_ok  = (take != '0) && (space >= LVL_W'(take));
    take_eff  = shift_ok ? take : '0;
    eos_hit   = !eos_pend && src.in_eos && (32'(src.in_bytes) <= IN_BYTES) &&
                ((src.in_bytes == '0) || shift_ok);
    formable  = (level >= LVL_W'(OUT_BYTES)) ||
                (eos_pend && ((level != '0) || !(axis.out_valid && axis.out_last)));
    load      = formable && (!axis.out_valid || axis.out_ready);
    beat_n    = load ? BEAT_W'(min_u(32'(level), OUT_BYTES)) : '0;
    beat_last = eos_pend && (level <= LVL_W'(OUT_BYTES));
    beat_keep = OUT_BYTES'(keep_mask(32'(beat_n)));
    for (int j = 0; j < int'(OUT_BYTES); j++) begin
      beat_data[j] = beat_keep[j] ? rd_data[j] : 8'h00;
    end
  end

  assign src.in_shift = shift_ok;
  assign src.in_take  = take_eff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      eos_pend       <= 1'b0;
      src.in_eos_ack <= 1'b0;
      axis.out_valid <= 1'b0;
      axis.out_last  <= 1'b0;
      axis.out_keep  <= '0;
      axis.out_data  <= '0;
    end else begin
      wr_ptr         <= wr_ptr + PTR_W'(take_eff);
      rd_ptr         <= rd_ptr + PTR_W'(beat_n);
      level          <= level + LVL_W'(take_eff) - LVL_W'(beat_n);
      src.in_eos_ack <= eos_hit;
      if (eos_hit) begin
        eos_pend <= 1'b1;
      end else if (axis.out_valid && axis.out_ready && axis.out_last) begin
        eos_pend <= 1'b0;
      end
      if (load) begin
        axis.out_valid <= 1'b1;
        axis.out_data  <= beat_data;
        axis.out_keep  <= beat_keep;
        axis.out_last  <= beat_last;
      end else if (axis.out_valid && axis.out_ready) begin
        axis.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_return_pack_fifo.sv
// Directed bench for return_pack_fifo: steady flow, backpressure, tails, wrap and reset.
module tb_return_pack_fifo;
  import return_pack_pkg::*;

  localparam int IN_BYTES  = 16;
  localparam int OUT_BYTES = 8;
  localparam int DEPTH     = 64;
  localparam int MAX_AVAIL = 34;
  localparam int AVAIL_W   = $clog2(MAX_AVAIL + 1);

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic [$clog2(DEPTH):0] level;

  shift_src_if #(.IN_BYTES(IN_BYTES), .MAX_AVAIL(MAX_AVAIL)) src_if ();
  axis_if #(.OUT_BYTES(OUT_BYTES)) out_if ();

  return_pack_fifo #(
    .IN_BYTES (IN_BYTES),
    .OUT_BYTES(OUT_BYTES),
    .DEPTH    (DEPTH),
    .MAX_AVAIL(MAX_AVAIL)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .src   (src_if),
    .axis  (out_if),
    .level (level)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  logic [63:0] beat_data_q[$];
  logic [7:0]  beat_keep_q[$];
  logic        beat_last_q[$];
  int          beat_cyc_q[$];
  int cyc, first_shift_cyc, first_valid_cyc, first_take, ack_cnt, level_max;
  logic last_shift;

  // ---------------- driver ----------------
  task automatic clear_capture();
    beat_data_q.delete();
    beat_keep_q.delete();
    beat_last_q.delete();
    beat_cyc_q.delete();
    exp_q.delete();
    cyc = 0;
    first_shift_cyc = -1;
    first_valid_cyc = -1;
    first_take = -1;
    ack_cnt = 0;
    level_max = 0;
    last_shift = 1'b0;
  endtask

  // Called at a falling edge: drives source, samples, crosses one rising edge.
  task automatic tick();
    int t;
    int avail;
    logic ack;
    avail = src_q.size();
    src_if.in_bytes = AVAIL_W'((avail > MAX_AVAIL) ? MAX_AVAIL : avail);
    for (int i = 0; i < IN_BYTES; i++) src_if.in_data[i] = (i < avail) ? src_q[i] : 8'h00;
    #1;
    t = src_if.in_shift ? int'(src_if.in_take) : 0;
    last_shift = src_if.in_shift;
    if (src_if.in_shift && first_shift_cyc < 0) begin
      first_shift_cyc = cyc;
      first_take = int'(src_if.in_take);
    end
    if (out_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (int'(level) > level_max) level_max = int'(level);
    ack = src_if.in_eos_ack;
    if (ack) ack_cnt++;
    if (out_if.out_valid && out_if.out_ready) begin
      beat_data_q.push_back(out_if.out_data);
      beat_keep_q.push_back(out_if.out_keep);
      beat_last_q.push_back(out_if.out_last);
      beat_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    for (int i = 0; i < t; i++) void'(src_q.pop_front());
    if (ack) src_if.in_eos = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    src_if.in_eos = 1'b0;
    src_if.in_bytes = '0;
    src_if.in_data = '0;
    out_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    compared++; if (out_if.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", out_if.out_valid); end
    compared++; if (out_if.out_last !== 1'b0) begin mismatched++; $display("FAIL reset_last: got %0b want 0", out_if.out_last); end
    compared++; if (out_if.out_keep !== 8'h00) begin mismatched++; $display("FAIL reset_keep: got %h want 00", out_if.out_keep); end
    compared++; if (out_if.out_data !== 64'h0) begin mismatched++; $display("FAIL reset_data: got %h want 0", out_if.out_data); end
    compared++; if (level !== 7'd0) begin mismatched++; $display("FAIL reset_level: got %0d want 0", level); end
    compared++; if (src_if.in_eos_ack !== 1'b0) begin mismatched++; $display("FAIL reset_ack: got %0b want 0", src_if.in_eos_ack); end
    compared++; if (src_if.in_shift !== 1'b0 || src_if.in_take !== '0) begin mismatched++; $display("FAIL reset_shift: got %0b/%0d want 0/0", src_if.in_shift, src_if.in_take); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_steady();
    logic [63:0] w;
    int nb;
    clear_capture();
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 80; k++) src_q.push_back(8'(k));
    for (int c = 0; c < 40 && beat_data_q.size() < 10; c++) tick();
    compared++; if (first_take != 16) begin mismatched++; $display("FAIL steady_take: got %0d want 16", first_take); end
    compared++; if (first_valid_cyc - first_shift_cyc != 2) begin mismatched++; $display("FAIL steady_latency: got %0d want 2", first_valid_cyc - first_shift_cyc); end
    nb = beat_data_q.size();
    compared++; if (nb != 10) begin mismatched++; $display("FAIL steady_beats: got %0d want 10", nb); end
    if (nb >= 10) begin
      compared++; if (beat_cyc_q[9] - beat_cyc_q[0] != 9) begin mismatched++; $display("FAIL steady_rate: got %0d cycles want 9", beat_cyc_q[9] - beat_cyc_q[0]); end
    end
    for (int b = 0; b < nb && b < 10; b++) begin
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(b*8 + j);
      compared++; if (beat_data_q[b] !== w) begin mismatched++; $display("FAIL steady_data[%0d]: got %h want %h", b, beat_data_q[b], w); end
      compared++; if (beat_keep_q[b] !== 8'hFF || beat_last_q[b] !== 1'b0) begin mismatched++; $display("FAIL steady_keep[%0d]: got %h/%0b want ff/0", b, beat_keep_q[b], beat_last_q[b]); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w;
    int nb;
    clear_capture();
    out_if.out_ready = 1'b0;
    for (int k = 0; k < 72; k++) src_q.push_back(8'(100 + k));
    repeat (20) tick();
    compared++; if (level !== 7'd64) begin mismatched++; $display("FAIL bp_level_full: got %0d want 64", level); end
    for (int k = 72; k < 80; k++) src_q.push_back(8'(100 + k));
    tick();
    compared++; if (last_shift !== 1'b0 || level !== 7'd64) begin mismatched++; $display("FAIL bp_no_shift: got shift=%0b level=%0d want 0/64", last_shift, level); end
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(100 + j);
    compared++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== w) begin mismatched++; $display("FAIL bp_hold: got v=%0b %h want 1 %h", out_if.out_valid, out_if.out_data, w); end
    compared++; if (beat_data_q.size() != 0) begin mismatched++; $display("FAIL bp_no_beats: got %0d want 0", beat_data_q.size()); end
    out_if.out_ready = 1'b1;
    for (int c = 0; c < 60 && beat_data_q.size() < 10; c++) tick();
    repeat (2) tick();
    nb = beat_data_q.size();
    compared++; if (nb != 10) begin mismatched++; $display("FAIL bp_beats: got %0d want 10", nb); end
    for (int b = 0; b < nb && b < 10; b++) begin
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(100 + b*8 + j);
      compared++; if (beat_data_q[b] !== w || beat_keep_q[b] !== 8'hFF) begin mismatched++; $display("FAIL bp_data[%0d]: got %h/%h want %h/ff", b, beat_data_q[b], beat_keep_q[b], w); end
    end
    compared++; if (level !== 7'd0) begin mismatched++; $display("FAIL bp_level_empty: got %0d want 0", level); end
  endtask

  task automatic test_partial_tail();
    logic [63:0] w0, w1;
    clear_capture();
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 13; k++) src_q.push_back(8'(8'h40 + k));
    src_if.in_eos = 1'b1;
    repeat (8) tick();
    for (int j = 0; j < 8; j++) w0[j*8 +: 8] = 8'(8'h40 + j);
    w1 = '0;
    for (int j = 0; j < 5; j++) w1[j*8 +: 8] = 8'(8'h48 + j);
    compared++; if (ack_cnt != 1) begin mismatched++; $display("FAIL tail_ack: got %0d want 1", ack_cnt); end
    compared++; if (beat_data_q.size() != 2) begin mismatched++; $display("FAIL tail_beats: got %0d want 2", beat_data_q.size()); end
    if (beat_data_q.size() >= 2) begin
      compared++; if (beat_data_q[0] !== w0 || beat_keep_q[0] !== 8'hFF || beat_last_q[0] !== 1'b0) begin mismatched++; $display("FAIL tail_beat0: got %h/%h/%0b want %h/ff/0", beat_data_q[0], beat_keep_q[0], beat_last_q[0], w0); end
      compared++; if (beat_data_q[1] !== w1 || beat_keep_q[1] !== 8'h1F || beat_last_q[1] !== 1'b1) begin mismatched++; $display("FAIL tail_beat1: got %h/%h/%0b want %h/1f/1", beat_data_q[1], beat_keep_q[1], beat_last_q[1], w1); end
    end
    compared++; if (out_if.out_valid !== 1'b0 || level !== 7'd0) begin mismatched++; $display("FAIL tail_idle: got v=%0b level=%0d want 0/0", out_if.out_valid, level); end
  endtask

  task automatic test_empty_eos();
    clear_capture();
    out_if.out_ready = 1'b1;
    src_if.in_eos = 1'b1;
    repeat (6) tick();
    compared++; if (ack_cnt != 1) begin mismatched++; $display("FAIL empty_ack: got %0d want 1", ack_cnt); end
    compared++; if (beat_data_q.size() != 1) begin mismatched++; $display("FAIL empty_beats: got %0d want 1", beat_data_q.size()); end
    if (beat_data_q.size() >= 1) begin
      compared++; if (beat_keep_q[0] !== 8'h00 || beat_last_q[0] !== 1'b1 || beat_data_q[0] !== 64'h0) begin mismatched++; $display("FAIL empty_beat: got %h/%0b/%h want 00/1/0", beat_keep_q[0], beat_last_q[0], beat_data_q[0]); end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] w;
    logic [7:0] ek;
    int rem, n, nb;
    logic done;
    clear_capture();
    for (int p = 0; p < 100; p++) begin
      for (int j = 0; j < 5; j++) begin
        src_q.push_back(8'(p*5 + j + 3));
        exp_q.push_back(8'(p*5 + j + 3));
      end
      out_if.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_if.out_ready = 1'b1;
    src_if.in_eos = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      tick();
      if (beat_last_q.size() > 0) done = beat_last_q[beat_last_q.size()-1];
    end
    compared++; if (!done) begin mismatched++; $display("FAIL wrap_timeout: got no last beat want last beat"); end
    nb = beat_data_q.size();
    compared++; if (nb != 63) begin mismatched++; $display("FAIL wrap_beats: got %0d want 63", nb); end
    for (int b = 0; b < nb && exp_q.size() > 0; b++) begin
      rem = exp_q.size();
      n = (rem < 8) ? rem : 8;
      w = '0;
      for (int j = 0; j < n; j++) w[j*8 +: 8] = exp_q.pop_front();
      ek = 8'((1 << n) - 1);
      compared++; if (beat_data_q[b] !== w || beat_keep_q[b] !== ek || beat_last_q[b] !== (rem <= 8)) begin mismatched++; $display("FAIL wrap_beat[%0d]: got %h/%h/%0b want %h/%h/%0b", b, beat_data_q[b], beat_keep_q[b], beat_last_q[b], w, ek, rem <= 8); end
    end
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL wrap_bytes_left: got %0d want 0", exp_q.size()); end
    compared++; if (level_max > 64) begin mismatched++; $display("FAIL wrap_level_max: got %0d want <=64", level_max); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w;
    clear_capture();
    out_if.out_ready = 1'b0;
    for (int k = 0; k < 38; k++) src_q.push_back(8'(k + 1));
    repeat (6) tick();
    compared++; if (level !== 7'd30 || out_if.out_valid !== 1'b1) begin mismatched++; $display("FAIL mid_pre: got level=%0d v=%0b want 30/1", level, out_if.out_valid); end
    resetn = 1'b0;
    #1;
    compared++; if (out_if.out_valid !== 1'b0 || level !== 7'd0 || out_if.out_last !== 1'b0 || out_if.out_keep !== 8'h00) begin mismatched++; $display("FAIL mid_reset: got v=%0b level=%0d last=%0b keep=%h want 0/0/0/00", out_if.out_valid, level, out_if.out_last, out_if.out_keep); end
    src_q.delete();
    src_if.in_bytes = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    clear_capture();
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) src_q.push_back(8'(8'hA0 + k));
    src_if.in_eos = 1'b1;
    repeat (6) tick();
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8'hA0 + j);
    compared++; if (beat_data_q.size() != 1) begin mismatched++; $display("FAIL mid_beats: got %0d want 1", beat_data_q.size()); end
    if (beat_data_q.size() >= 1) begin
      compared++; if (beat_data_q[0] !== w || beat_keep_q[0] !== 8'hFF || beat_last_q[0] !== 1'b1) begin mismatched++; $display("FAIL mid_beat: got %h/%h/%0b want %h/ff/1", beat_data_q[0], beat_keep_q[0], beat_last_q[0], w); end
    end
    compared++; if (ack_cnt != 1) begin mismatched++; $display("FAIL mid_ack: got %0d want 1", ack_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_steady();
    test_backpressure();
    test_partial_tail();
    test_empty_eos();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
